dpram_port_arbiter: RTL and testbench

- Shares one synchronous port of the dual-port BRAM (clk-synchronous, registered read data, write-first-or-old-data not relied upon) between two requesters.
- Round-robin arbitration with a valid/ready request handshake and a registered-latency read response per requester.
- After every reset, runs a clear sequence that writes CLEAR_VALUE to every address before any requester is granted.
- Sits between two client engines and one BRAM port; the other BRAM port stays free for an independent agent.

---
 rtl/dpram_port_arbiter_pkg.sv | 24 ++
 rtl/dpram_port_arbiter_rr_arbiter2.sv | 47 ++++
 rtl/dpram_port_arbiter.sv | 128 ++++++++++++
 tb/tb_dpram_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// dpram_port_arbiter_pkg
// Shared types for the BRAM port arbiter: the controller state encoding,
// the one-bit requester index and a helper that turns an index into a
// one-hot grant vector.
package dpram_port_arbiter_pkg;

    // CLEAR initialises the memory after reset; ARB serves the requesters.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } arb_state_e;

    // Identifies one of the two requesters.
    typedef logic grant_idx_t;

    // Requester 1 counts as the last winner out of reset, so requester 0
    // wins the first tie.
    localparam grant_idx_t LAST_GRANT_RESET = 1'b1;

    function automatic logic [1:0] idx_to_onehot(input grant_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. A lone requester always wins. When both
// request, the one that did not win last time is granted.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   valid_0, valid_1   request lines (already masked by the caller)
//   grant              one-hot grant, combinational from the inputs
module rr_arbiter2
    import dpram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_0,
    input  logic       valid_1,
    output logic [1:0] grant
);

    grant_idx_t last_grant_q;
    grant_idx_t last_grant_d;
    grant_idx_t winner;

    // Choose a winner. Remember it only when a grant actually happens, so
    // idle cycles leave the fairness pointer unchanged.
    always_comb begin
        winner       = 1'b0;
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        if (valid_0 && valid_1) begin
            winner = ~last_grant_q;
        end else if (valid_1) begin
            winner = 1'b1;
        end
        if (valid_0 || valid_1) begin
            grant        = idx_to_onehot(winner);
            last_grant_d = winner;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= LAST_GRANT_RESET;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
// Shares one synchronous BRAM port between two requesters. After every
// reset, the block writes CLEAR_VALUE to every address. It then serves the
// requesters round-robin with a valid/ready handshake. A read accepted in
// cycle T returns its data with rsp_valid_n in cycle T+1.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/we/add/data_{0,1}      request channel per requester
//   req_ready_{0,1}                  request accepted this cycle
//   rsp_valid_{0,1}, rsp_data        read response (data shared)
//   busy                             clear sequence in progress
//   mem_we, mem_add, mem_data_w      drive the BRAM port
//   mem_data_r                       registered read data from the BRAM
module dpram_port_arbiter
    import dpram_port_arbiter_pkg::*;
#(
    parameter int                    data_width    = 8,
    parameter int                    address_width = 7,
    parameter logic [data_width-1:0] CLEAR_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_0,
    input  logic                     req_valid_1,
    input  logic                     req_we_0,
    input  logic                     req_we_1,
    input  logic [address_width-1:0] req_add_0,
    input  logic [address_width-1:0] req_add_1,
    input  logic [data_width-1:0]    req_data_0,
    input  logic [data_width-1:0]    req_data_1,
    output logic                     req_ready_0,
    output logic                     req_ready_1,
    output logic                     rsp_valid_0,
    output logic                     rsp_valid_1,
    output logic [data_width-1:0]    rsp_data,
    output logic                     busy,
    output logic                     mem_we,
    output logic [address_width-1:0] mem_add,
    output logic [data_width-1:0]    mem_data_w,
    input  logic [data_width-1:0]    mem_data_r
);

    arb_state_e               state_q, state_d;
    logic [address_width:0]   clear_addr_q, clear_addr_d;
    logic [address_width-1:0] mem_add_q, mem_add_d;
    logic                     rsp_valid_0_q, rsp_valid_0_d;
    logic                     rsp_valid_1_q, rsp_valid_1_d;
    logic                     arb_valid_0, arb_valid_1;
    logic [1:0]               grant;

    // Requests are masked during clear. This keeps them pending without
    // moving the fairness pointer.
    assign arb_valid_0 = req_valid_0 && (state_q == ST_ARB);
    assign arb_valid_1 = req_valid_1 && (state_q == ST_ARB);

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_0 (arb_valid_0),
        .valid_1 (arb_valid_1),
        .grant   (grant)
    );

    // Port mux and next-state logic. When nothing is granted in ARB, the
    // address holds its previous value, so the BRAM address bus stays quiet.
    always_comb begin
        state_d       = state_q;
        clear_addr_d  = clear_addr_q;
        mem_we        = 1'b0;
        mem_add       = mem_add_q;
        mem_data_w    = '0;
        req_ready_0   = 1'b0;
        req_ready_1   = 1'b0;
        rsp_valid_0_d = 1'b0;
        rsp_valid_1_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we       = 1'b1;
                mem_add      = clear_addr_q[address_width-1:0];
                mem_data_w   = CLEAR_VALUE;
                clear_addr_d = clear_addr_q + 1'b1;
                if (&clear_addr_q[address_width-1:0]) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (grant[0]) begin
                    req_ready_0   = 1'b1;
                    mem_we        = req_we_0;
                    mem_add       = req_add_0;
                    mem_data_w    = req_data_0;
                    rsp_valid_0_d = ~req_we_0;
                end else if (grant[1]) begin
                    req_ready_1   = 1'b1;
                    mem_we        = req_we_1;
                    mem_add       = req_add_1;
                    mem_data_w    = req_data_1;
                    rsp_valid_1_d = ~req_we_1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        mem_add_d = mem_add;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_CLEAR;
            clear_addr_q  <= '0;
            mem_add_q     <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_addr_q  <= clear_addr_d;
            mem_add_q     <= mem_add_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
        end
    end

    assign busy        = (state_q == ST_CLEAR);
    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    // The BRAM output register already aligns with the response flags.
    assign rsp_data    = mem_data_r;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter
// Directed bench for dpram_port_arbiter. A behavioural BRAM with registered
// read data sits behind the arbiter. Expected values are hand-computed
// constants per vector.
module tb_dpram_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_valid_0, req_valid_1;
    logic       req_we_0, req_we_1;
    logic [6:0] req_add_0, req_add_1;
    logic [7:0] req_data_0, req_data_1;
    logic       req_ready_0, req_ready_1;
    logic       rsp_valid_0, rsp_valid_1;
    logic [7:0] rsp_data;
    logic       busy;
    logic       mem_we;
    logic [6:0] mem_add;
    logic [7:0] mem_data_w;
    logic [7:0] mem_data_r;

    logic [7:0] mem_model [0:127];

    int vector_count;
    int miscompare_count;

    dpram_port_arbiter #(
        .data_width    (8),
        .address_width (7),
        .CLEAR_VALUE   (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_we_0    (req_we_0),
        .req_we_1    (req_we_1),
        .req_add_0   (req_add_0),
        .req_add_1   (req_add_1),
        .req_data_0  (req_data_0),
        .req_data_1  (req_data_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .mem_we      (mem_we),
        .mem_add     (mem_add),
        .mem_data_w  (mem_data_w),
        .mem_data_r  (mem_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM port model. The write lands at the edge, and read data is
    // registered one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_add] <= mem_data_w;
        mem_data_r <= mem_model[mem_add];
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic       v0, input logic we0, input logic [6:0] a0, input logic [7:0] d0,
        input logic       v1, input logic we1, input logic [6:0] a1, input logic [7:0] d1
    );
        req_valid_0 = v0; req_we_0 = we0; req_add_0 = a0; req_data_0 = d0;
        req_valid_1 = v1; req_we_1 = we1; req_add_1 = a1; req_data_1 = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    initial begin
        int prev;
        int g;
        vector_count     = 0;
        miscompare_count = 0;
        rst_n = 1'b0;
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);

        // Reset values
        #2;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_ready0", req_ready_0, 0);
        checkOutput("rst_ready1", req_ready_1, 0);
        checkOutput("rst_rspv0", rsp_valid_0, 0);
        checkOutput("rst_rspv1", rsp_valid_1, 0);

        // Full clear sequence with no requests
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        for (int i = 0; i < 128; i++) begin
            checkOutput("clr_busy", busy, 1);
            checkOutput("clr_we", mem_we, 1);
            checkOutput("clr_add", mem_add, i);
            checkOutput("clr_data", mem_data_w, 8'h00);
            checkOutput("clr_ready0", req_ready_0, 0);
            nextCycle();
            applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        end
        checkOutput("arb_busy", busy, 0);
        checkOutput("idle_we", mem_we, 0);
        checkOutput("idle_add_hold", mem_add, 127);

        // Read of address 5 returns the cleared value
        applyStimulus(1, 0, 7'd5, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("rd5_ready0", req_ready_0, 1);
        checkOutput("rd5_add", mem_add, 5);
        checkOutput("rd5_we", mem_we, 0);
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("rd5_rspv0", rsp_valid_0, 1);
        checkOutput("rd5_rspv1", rsp_valid_1, 0);
        checkOutput("rd5_data", rsp_data, 8'h00);
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("rd5_rspv0_drop", rsp_valid_0, 0);

        // Write then read the same address in consecutive cycles
        nextCycle();
        applyStimulus(1, 1, 7'd3, 8'hA5, 0, 0, 7'd0, 8'h00);
        checkOutput("wr3_ready0", req_ready_0, 1);
        checkOutput("wr3_we", mem_we, 1);
        checkOutput("wr3_data", mem_data_w, 8'hA5);
        nextCycle();
        applyStimulus(1, 0, 7'd3, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("rd3_ready0", req_ready_0, 1);
        checkOutput("rd3_we", mem_we, 0);
        checkOutput("wr_no_rsp", rsp_valid_0, 0);
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("rd3_rspv0", rsp_valid_0, 1);
        checkOutput("rd3_data", rsp_data, 8'hA5);
        checkOutput("rd3_idle_we", mem_we, 0);
        checkOutput("rd3_idle_hold", mem_add, 3);

        // Preload addresses 10 and 20, leaving requester 1 as last winner
        nextCycle();
        applyStimulus(1, 1, 7'd10, 8'h3C, 0, 0, 7'd0, 8'h00);
        checkOutput("wr10_ready0", req_ready_0, 1);
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 1, 1, 7'd20, 8'hC3);
        checkOutput("wr20_ready1", req_ready_1, 1);
        checkOutput("wr20_ready0", req_ready_0, 0);
        checkOutput("wr20_add", mem_add, 20);

        // Both requesters read continuously, so grants alternate
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            applyStimulus(1, 0, 7'd10, 8'h00, 1, 0, 7'd20, 8'h00);
            g = k % 2;
            checkOutput("rr_ready0", req_ready_0, (g == 0) ? 1 : 0);
            checkOutput("rr_ready1", req_ready_1, (g == 1) ? 1 : 0);
            checkOutput("rr_add", mem_add, (g == 1) ? 20 : 10);
            if (k > 0) begin
                checkOutput("rr_rspv0", rsp_valid_0, (prev == 0) ? 1 : 0);
                checkOutput("rr_rspv1", rsp_valid_1, (prev == 1) ? 1 : 0);
                checkOutput("rr_data", rsp_data, (prev == 1) ? 8'hC3 : 8'h3C);
            end
            prev = g;
        end
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("rr_last_rspv1", rsp_valid_1, 1);
        checkOutput("rr_last_rspv0", rsp_valid_0, 0);
        checkOutput("rr_last_data", rsp_data, 8'hC3);

        // Reset between read acceptance and the following edge
        nextCycle();
        applyStimulus(1, 0, 7'd10, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("abort_ready0", req_ready_0, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_ready0_rst", req_ready_0, 0);
        checkOutput("abort_busy", busy, 1);
        checkOutput("abort_rspv0_now", rsp_valid_0, 0);
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("abort_rspv0", rsp_valid_0, 0);
        checkOutput("abort_rspv1", rsp_valid_1, 0);
        checkOutput("abort_clr_we", mem_we, 1);
        checkOutput("abort_clr_add", mem_add, 0);

        // Release with requester 1 waiting, then reset again at clear_addr 60
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 0, 7'd0, 8'h00, 1, 0, 7'd20, 8'h00);
        for (int i = 0; i < 60; i++) begin
            checkOutput("clr2_add", mem_add, i);
            checkOutput("clr2_ready1", req_ready_1, 0);
            nextCycle();
            applyStimulus(0, 0, 7'd0, 8'h00, 1, 0, 7'd20, 8'h00);
        end
        checkOutput("clr2_add60", mem_add, 60);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_add", mem_add, 0);
        checkOutput("mid_rst_busy", busy, 1);
        checkOutput("mid_rst_we", mem_we, 1);
        checkOutput("mid_rst_ready1", req_ready_1, 0);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(0, 0, 7'd0, 8'h00, 1, 0, 7'd20, 8'h00);
        for (int i = 0; i < 128; i++) begin
            checkOutput("clr3_add", mem_add, i);
            checkOutput("clr3_busy", busy, 1);
            checkOutput("clr3_ready1", req_ready_1, 0);
            nextCycle();
            applyStimulus(0, 0, 7'd0, 8'h00, 1, 0, 7'd20, 8'h00);
        end
        checkOutput("held_ready1", req_ready_1, 1);
        checkOutput("held_busy", busy, 0);
        checkOutput("held_add", mem_add, 20);
        checkOutput("held_we", mem_we, 0);
        nextCycle();
        applyStimulus(0, 0, 7'd0, 8'h00, 0, 0, 7'd0, 8'h00);
        checkOutput("held_rspv1", rsp_valid_1, 1);
        checkOutput("held_data", rsp_data, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule
